// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel LED PWM controller with OFF/STATIC/BLINK/BREATHE modes per channel.
// Configuration is held in a single shadow slot and applied on PWM frame boundaries.
module rgb_pwm_ctrl #(
  parameter int CHANNELS     = 3,
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 48,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [2:0]          cfg_chan_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [PWM_BITS-1:0] cfg_level_i,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                frame_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int PROD_W = 2 * PWM_BITS;

  localparam logic [PWM_BITS-1:0] CNT_MAX  = '1;
  localparam logic [PWM_BITS-1:0] CNT_ZERO = '0;
  localparam logic [PRE_W-1:0]    PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STATIC  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  // timebase
  logic [PRE_W-1:0]    pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                tick;
  logic                frame;

  // shadow slot
  logic                pending;
  logic [2:0]          sh_chan;
  mode_e               sh_mode;
  logic [PWM_BITS-1:0] sh_level;
  logic                accept;

  // per-channel configuration
  mode_e               mode_q   [CHANNELS];
  logic [PWM_BITS-1:0] level_q  [CHANNELS];
  mode_e               mode_nxt [CHANNELS];
  logic [PWM_BITS-1:0] level_nxt[CHANNELS];

  // shared effect generators
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] ramp;
  logic                dir_down;

  logic [PRE_W-1:0]    pre_cnt_nxt;
  logic [PWM_BITS-1:0] pwm_cnt_nxt;
  logic [BLK_W-1:0]    blink_cnt_nxt;
  logic                blink_phase_nxt;
  logic [PWM_BITS-1:0] ramp_nxt;
  logic                dir_down_nxt;

  logic [PROD_W-1:0]   breathe_prod[CHANNELS];
  logic [PWM_BITS-1:0] duty_nxt    [CHANNELS];
  logic [CHANNELS-1:0] pwm_nxt;

  assign tick        = (pre_cnt == PRE_LAST);
  assign frame       = tick && (pwm_cnt == CNT_MAX);
  assign cfg_ready_o = !pending;
  assign accept      = cfg_valid_i && !pending;

  always_comb begin
    pre_cnt_nxt     = tick ? '0 : pre_cnt + 1'b1;
    pwm_cnt_nxt     = tick ? pwm_cnt + 1'b1 : pwm_cnt;
    blink_cnt_nxt   = blink_cnt;
    blink_phase_nxt = blink_phase;
    ramp_nxt        = ramp;
    dir_down_nxt    = dir_down;

    if (frame) begin
      if (blink_cnt == BLK_LAST) begin
        blink_cnt_nxt   = '0;
        blink_phase_nxt = !blink_phase;
      end else begin
        blink_cnt_nxt = blink_cnt + 1'b1;
      end

      if (dir_down) begin
        ramp_nxt = ramp - 1'b1;
        if (ramp_nxt == CNT_ZERO) dir_down_nxt = 1'b0;
      end else begin
        ramp_nxt = ramp + 1'b1;
        if (ramp_nxt == CNT_MAX) dir_down_nxt = 1'b1;
      end
    end
  end

  // Channel registers take the shadow value on a frame; out-of-range indices match no channel.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      mode_nxt[c]  = mode_q[c];
      level_nxt[c] = level_q[c];
      if (frame && pending && (sh_chan == 3'(c))) begin
        mode_nxt[c]  = sh_mode;
        level_nxt[c] = sh_level;
      end
    end
  end

  // pwm_o is registered from next-cycle values so the first output of a frame lines up with frame_o.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      breathe_prod[c] = PROD_W'(level_nxt[c]) * PROD_W'(ramp_nxt);
      case (mode_nxt[c])
        MODE_STATIC:  duty_nxt[c] = level_nxt[c];
        MODE_BLINK:   duty_nxt[c] = blink_phase_nxt ? level_nxt[c] : CNT_ZERO;
        MODE_BREATHE: duty_nxt[c] = PWM_BITS'(breathe_prod[c] >> PWM_BITS);
        default:      duty_nxt[c] = CNT_ZERO;
      endcase
      pwm_nxt[c] = (duty_nxt[c] == CNT_MAX) || (pwm_cnt_nxt < duty_nxt[c]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt     <= '0;
      pwm_cnt     <= '0;
      frame_o     <= 1'b0;
      pending     <= 1'b0;
      sh_chan     <= '0;
      sh_mode     <= MODE_OFF;
      sh_level    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      ramp        <= '0;
      dir_down    <= 1'b0;
      pwm_o       <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]  <= MODE_OFF;
        level_q[c] <= '0;
      end
    end else begin
      pre_cnt     <= pre_cnt_nxt;
      pwm_cnt     <= pwm_cnt_nxt;
      frame_o     <= frame;
      blink_cnt   <= blink_cnt_nxt;
      blink_phase <= blink_phase_nxt;
      ramp        <= ramp_nxt;
      dir_down    <= dir_down_nxt;
      pwm_o       <= pwm_nxt;
      for (int c = 0; c < CHANNELS; c++) begin
        mode_q[c]  <= mode_nxt[c];
        level_q[c] <= level_nxt[c];
      end

      // Accept and apply never coincide: acceptance needs an empty slot.
      if (accept) begin
        pending  <= 1'b1;
        sh_chan  <= cfg_chan_i;
        sh_mode  <= mode_e'(cfg_mode_i);
        sh_level <= cfg_level_i;
      end else if (frame && pending) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
